// File: rtl/wc_host_link.sv
// Host-side link controller for the WC_5_4 chip: buffers a tile, streams it onto D, captures Z results.
// Define WC_HOST_LINK_ZREG_EN to register chip_z through one input flop before capture.
module wc_host_link #(
  parameter int IN_WORDS  = 25,
  parameter int OUT_WORDS = 4,
  parameter int LAT       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [9:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       chip_rst,
  output logic [9:0] chip_d,
  input  logic [9:0] chip_z,
  output logic       busy,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    S_FILL  = 3'd0,
    S_SEND  = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam int WW = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
  localparam int RW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam int TW = $clog2(LAT + 1);
`ifdef WC_HOST_LINK_ZREG_EN
  localparam int WAIT_CYC = LAT;
`else
  localparam int WAIT_CYC = LAT - 1;
`endif
  localparam logic [WW-1:0] W_LAST = WW'(IN_WORDS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(OUT_WORDS - 1);
  localparam logic [TW-1:0] T_LAST = TW'(WAIT_CYC - 1);

  state_t        state, state_nxt;
  logic [WW-1:0] wcnt;
  logic [RW-1:0] rcnt;
  logic [TW-1:0] tcnt;
  logic [9:0]    ibuf [IN_WORDS];
  logic [9:0]    obuf [OUT_WORDS];
  logic [9:0]    z_cap;
  logic          s_fire;
  logic          m_fire;

`ifdef WC_HOST_LINK_ZREG_EN
  logic [9:0] zreg;
  always_ff @(posedge clk) begin
    if (rst) zreg <= '0;
    else     zreg <= chip_z;
  end
  assign z_cap = zreg;
`else
  assign z_cap = chip_z;
`endif

  // s_ready waits for chip_rst to drop so the chip is out of reset before a new frame.
  assign s_ready   = (state == S_FILL) && !chip_rst;
  assign s_fire    = s_valid && s_ready;
  assign m_valid   = (state == S_DRAIN);
  assign m_fire    = m_valid && m_ready;
  assign m_data    = (state == S_DRAIN) ? obuf[rcnt] : 10'd0;
  assign chip_d    = (state == S_SEND) ? ibuf[wcnt] : 10'd0;
  assign busy      = (state != S_FILL);
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (s_fire && wcnt == W_LAST) state_nxt = S_SEND;
      S_SEND:  if (wcnt == W_LAST) state_nxt = (WAIT_CYC == 0) ? S_CAPT : S_WAIT;
      S_WAIT:  if (tcnt == T_LAST) state_nxt = S_CAPT;
      S_CAPT:  if (rcnt == R_LAST) state_nxt = S_DRAIN;
      S_DRAIN: if (m_fire && rcnt == R_LAST) state_nxt = S_FILL;
      default: state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    chip_rst <= rst;
    if (rst) begin
      state <= S_FILL;
      wcnt  <= '0;
      rcnt  <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FILL:  if (s_fire) wcnt <= (wcnt == W_LAST) ? '0 : wcnt + 1'b1;
        S_SEND:  wcnt <= (wcnt == W_LAST) ? '0 : wcnt + 1'b1;
        S_WAIT:  tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
        S_CAPT:  rcnt <= (rcnt == R_LAST) ? '0 : rcnt + 1'b1;
        S_DRAIN: if (m_fire) rcnt <= (rcnt == R_LAST) ? '0 : rcnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Frame buffers carry no reset; their contents are only read after being written.
  always_ff @(posedge clk) begin
    if (!rst && state == S_FILL && s_fire) ibuf[wcnt] <= s_data;
    if (!rst && state == S_CAPT) obuf[rcnt] <= z_cap;
  end

endmodule
